charlcd_bus_driver: RTL and testbench

Downstream stage of apb_seg_charlcd: converts byte-wide LCD command/data requests into HD44780-compatible 8-bit write cycles on LCD_RS/LCD_RW/LCD_EN/LCD_DATA, with the required setup, enable-pulse, hold and execution timing. Runs the power-on initialisation sequence autonomously after reset. Upstream register logic sees a simple valid/ready byte interface in the LCDCLK domain.

---
 rtl/charlcd_pkg.sv | 39 +++
 rtl/charlcd_bus_driver_if.sv | 10 +
 rtl/charlcd_timer.sv | 23 ++
 rtl/charlcd_bus_driver.sv | 147 ++++++++++++++
 tb/tb_charlcd_bus_driver.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/charlcd_pkg.sv
// Shared types and constants for the character-LCD bus stages: FSM state
// encoding, HD44780 opcodes and the power-on init ROM.
package charlcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT  = 3'd0,
        INIT_LOAD = 3'd1,
        IDLE      = 3'd2,
        SETUP     = 3'd3,
        EN_HI     = 3'd4,
        HOLD      = 3'd5,
        EXEC_WAIT = 3'd6
    } lcd_state_t;

    localparam logic [7:0] LCD_CLEAR        = 8'h01;
    localparam logic [7:0] LCD_HOME         = 8'h02;
    localparam logic [7:0] LCD_HOME_ALT     = 8'h03;
    localparam logic [7:0] LCD_ENTRY_INC    = 8'h06;
    localparam logic [7:0] LCD_DISP_ON      = 8'h0C;
    localparam logic [7:0] LCD_FUNC_8BIT_2L = 8'h38;

    localparam int INIT_LEN = 6;

    // Function set is sent three times so the panel syncs regardless of its prior bus mode.
    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_rom = LCD_FUNC_8BIT_2L;
            3'd3:             init_rom = LCD_DISP_ON;
            3'd4:             init_rom = LCD_CLEAR;
            3'd5:             init_rom = LCD_ENTRY_INC;
            default:          init_rom = 8'h00;
        endcase
    endfunction

    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == LCD_CLEAR || data == LCD_HOME || data == LCD_HOME_ALT);
    endfunction

endpackage

// File: rtl/charlcd_bus_driver_if.sv
// Byte-wide valid/ready request channel from the LCD register logic.
interface charlcd_bus_driver_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rs;
    logic [7:0] cmd_data;

    modport master (output cmd_valid, output cmd_rs, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_rs, input cmd_data, output cmd_ready);
endinterface

// File: rtl/charlcd_timer.sv
// Loadable down-counter that stops at zero; zero flag is a decode of the count.
module charlcd_timer #(
    parameter int CNT_W = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);
endmodule

// File: rtl/charlcd_bus_driver.sv
// HD44780 8-bit write-cycle generator with autonomous power-on init.
//   state     | meaning
//   PWR_WAIT  | post-reset settle time before the first init write
//   INIT_LOAD | fetch next init ROM byte onto RS/DATA
//   IDLE      | init done, accepting requests
//   SETUP     | RS/DATA stable, EN low
//   EN_HI     | enable strobe high
//   HOLD      | EN low, RS/DATA held
//   EXEC_WAIT | panel execution time (long for clear/home)
module charlcd_bus_driver
    import charlcd_pkg::*;
#(
    parameter int INIT_WAIT = 150000,
    parameter int T_SETUP   = 1,
    parameter int T_EN_HIGH = 5,
    parameter int T_HOLD    = 1,
    parameter int T_EXEC    = 400,
    parameter int T_CLEAR   = 16400,
    parameter int CNT_W     = 18
) (
    input  logic                 LCDCLK,
    input  logic                 PRESETn,
    charlcd_bus_driver_if.slave  cmd,
    output logic                 busy,
    output logic                 init_done,
    output logic                 LCD_RS,
    output logic                 LCD_RW,
    output logic                 LCD_EN,
    output logic [7:0]           LCD_DATA
);
    lcd_state_t       state;
    logic [2:0]       init_idx;
    logic             pwr_armed;
    logic             ready_q;
    logic             handshake;
    logic             timer_zero;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;

    assign handshake     = cmd.cmd_valid & ready_q;
    assign cmd.cmd_ready = ready_q;
    assign LCD_RW        = 1'b0;

    // Timer is loaded on the same edge that enters each timed state.
    // PWR_WAIT has no entry edge after reset, so its first cycle arms the timer.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        case (state)
            PWR_WAIT: if (!pwr_armed) begin
                timer_load = 1'b1;
                timer_val  = CNT_W'(INIT_WAIT - 2);
            end
            INIT_LOAD: begin
                timer_load = 1'b1;
                timer_val  = CNT_W'(T_SETUP - 1);
            end
            IDLE: if (handshake) begin
                timer_load = 1'b1;
                timer_val  = CNT_W'(T_SETUP - 1);
            end
            SETUP: if (timer_zero) begin
                timer_load = 1'b1;
                timer_val  = CNT_W'(T_EN_HIGH - 1);
            end
            EN_HI: if (timer_zero) begin
                timer_load = 1'b1;
                timer_val  = CNT_W'(T_HOLD - 1);
            end
            HOLD: if (timer_zero) begin
                timer_load = 1'b1;
                timer_val  = is_slow_cmd(LCD_RS, LCD_DATA) ? CNT_W'(T_CLEAR - 1)
                                                           : CNT_W'(T_EXEC - 1);
            end
            default: ;
        endcase
    end

    charlcd_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (LCDCLK),
        .rst_n    (PRESETn),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    always_ff @(posedge LCDCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= PWR_WAIT;
            init_idx  <= 3'd0;
            pwr_armed <= 1'b0;
            ready_q   <= 1'b0;
            busy      <= 1'b1;
            init_done <= 1'b0;
            LCD_RS    <= 1'b0;
            LCD_EN    <= 1'b0;
            LCD_DATA  <= 8'h00;
        end else begin
            ready_q <= 1'b0;
            busy    <= 1'b1;
            case (state)
                PWR_WAIT: begin
                    pwr_armed <= 1'b1;
                    if (pwr_armed && timer_zero)
                        state <= INIT_LOAD;
                end
                INIT_LOAD: begin
                    LCD_RS   <= 1'b0;
                    LCD_DATA <= init_rom(init_idx);
                    state    <= SETUP;
                end
                IDLE: begin
                    if (handshake) begin
                        LCD_RS   <= cmd.cmd_rs;
                        LCD_DATA <= cmd.cmd_data;
                        state    <= SETUP;
                    end else begin
                        ready_q <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                SETUP: if (timer_zero) begin
                    LCD_EN <= 1'b1;
                    state  <= EN_HI;
                end
                EN_HI: if (timer_zero) begin
                    LCD_EN <= 1'b0;
                    state  <= HOLD;
                end
                HOLD: if (timer_zero)
                    state <= EXEC_WAIT;
                EXEC_WAIT: if (timer_zero) begin
                    if (init_done) begin
                        state <= IDLE;
                    end else if (init_idx == 3'(INIT_LEN - 1)) begin
                        init_done <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        init_idx <= init_idx + 3'd1;
                        state    <= INIT_LOAD;
                    end
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_charlcd_bus_driver.sv
// Bench for charlcd_bus_driver: EN-pulse monitor plus a timing/byte reference model.
module tb_charlcd_bus_driver;
    localparam int INIT_WAIT = 20;
    localparam int T_SETUP   = 1;
    localparam int T_EN_HIGH = 3;
    localparam int T_HOLD    = 1;
    localparam int T_EXEC    = 8;
    localparam int T_CLEAR   = 30;

    logic       LCDCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       busy, init_done, LCD_RS, LCD_RW, LCD_EN;
    logic [7:0] LCD_DATA;

    charlcd_bus_driver_if cmd_bus();

    charlcd_bus_driver #(
        .INIT_WAIT(INIT_WAIT), .T_SETUP(T_SETUP), .T_EN_HIGH(T_EN_HIGH),
        .T_HOLD(T_HOLD), .T_EXEC(T_EXEC), .T_CLEAR(T_CLEAR), .CNT_W(18)
    ) dut (
        .LCDCLK(LCDCLK), .PRESETn(PRESETn), .cmd(cmd_bus),
        .busy(busy), .init_done(init_done), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
        .LCD_EN(LCD_EN), .LCD_DATA(LCD_DATA)
    );

    always #5 LCDCLK = ~LCDCLK;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    always @(posedge LCDCLK) cyc <= cyc + 1;

    // Pulse monitor: one record per EN high period, sampled on falling clock edges.
    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         rise;
        int         fall;
        bit         setup_ok;
        bit         stable;
        bit         hold_ok;
    } pulse_t;

    pulse_t     pulses[$];
    pulse_t     cur;
    bit         en_prev = 0;
    bit         rw_seen = 0;
    logic       rs_prev = 0;
    logic [7:0] data_prev = 8'h00;

    always @(negedge LCDCLK) begin
        if (LCD_RW !== 1'b0) rw_seen = 1;
        if (LCD_EN === 1'b1 && !en_prev) begin
            cur.rs       = LCD_RS;
            cur.data     = LCD_DATA;
            cur.rise     = cyc;
            cur.setup_ok = (rs_prev === LCD_RS) && (data_prev === LCD_DATA);
            cur.stable   = 1;
        end else if (LCD_EN === 1'b1) begin
            if (LCD_RS !== cur.rs || LCD_DATA !== cur.data) cur.stable = 0;
        end else if (en_prev) begin
            cur.fall    = cyc;
            cur.hold_ok = (LCD_RS === cur.rs) && (LCD_DATA === cur.data);
            pulses.push_back(cur);
        end
        en_prev   = (LCD_EN === 1'b1);
        rs_prev   = LCD_RS;
        data_prev = LCD_DATA;
    end

    // Reference model: panel execution time and request-to-ready latency.
    function automatic int exec_wait(input logic rs, input logic [7:0] d);
        if (rs == 1'b0 && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return T_CLEAR;
        return T_EXEC;
    endfunction

    function automatic int ready_latency(input logic rs, input logic [7:0] d);
        return T_SETUP + T_EN_HIGH + T_HOLD + exec_wait(rs, d) + 1;
    endfunction

    logic [7:0] init_bytes [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    task automatic tick();
        @(negedge LCDCLK);
        #1;
    endtask

    task automatic send(input logic rs, input logic [7:0] d, input bit keep, output int hs);
        hs = -1;
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_rs    = rs;
        cmd_bus.cmd_data  = d;
        for (int i = 0; i < 300; i++) begin
            if (cmd_bus.cmd_ready === 1'b1) begin
                @(posedge LCDCLK);
                #1;
                hs = cyc;
                break;
            end
            tick();
        end
        tick();
        if (!keep) cmd_bus.cmd_valid = 1'b0;
        checks++;
        if (hs < 0) begin
            errors++;
            $display("FAIL send_handshake: no handshake for %02h within 300 cycles", d);
        end
    endtask

    task automatic wait_ready(input string tag, output int rc);
        rc = -1;
        for (int i = 0; i < 300; i++) begin
            if (cmd_bus.cmd_ready === 1'b1) begin
                rc = cyc;
                break;
            end
            tick();
        end
        checks++;
        if (rc < 0) begin
            errors++;
            $display("FAIL %s_ready_timeout: cmd_ready never returned high", tag);
        end
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_rs    = 1'b0;
        cmd_bus.cmd_data  = 8'h00;
        repeat (3) tick();
        checks++;
        if ({LCD_EN, LCD_RS, LCD_RW, LCD_DATA, cmd_bus.cmd_ready, busy, init_done} !==
            {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: en/rs/rw/data/ready/busy/done got %b expected %b",
                     {LCD_EN, LCD_RS, LCD_RW, LCD_DATA, cmd_bus.cmd_ready, busy, init_done},
                     {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
        end
    endtask

    // Releases reset and checks the whole init sequence; noise holds a request during init.
    task automatic test_init_sequence(input string tag, input bit noise);
        int rel, t_done, exp_gap;
        bit bad_status;
        pulses.delete();
        rw_seen = 0;
        bad_status = 0;
        if (noise) begin
            cmd_bus.cmd_valid = 1'b1;
            cmd_bus.cmd_rs    = 1'b1;
            cmd_bus.cmd_data  = 8'hAA;
        end
        rel = cyc;
        PRESETn = 1'b1;
        t_done = -1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (init_done === 1'b1) begin
                t_done = cyc;
                break;
            end
            if (cmd_bus.cmd_ready !== 1'b0 || busy !== 1'b1) bad_status = 1;
        end
        cmd_bus.cmd_valid = 1'b0;

        checks++;
        if (t_done < 0) begin
            errors++;
            $display("FAIL %s_done_timeout: init_done never rose", tag);
        end
        checks++;
        if (bad_status) begin
            errors++;
            $display("FAIL %s_busy_during_init: ready/busy got active-idle, required ready=0 busy=1", tag);
        end
        checks++;
        if (pulses.size() != 6) begin
            errors++;
            $display("FAIL %s_pulse_count: got %0d required 6", tag, pulses.size());
        end else begin
            checks++;
            if (pulses[0].rise != rel + INIT_WAIT + 1 + T_SETUP) begin
                errors++;
                $display("FAIL %s_first_rise: got cycle %0d required %0d", tag,
                         pulses[0].rise - rel, INIT_WAIT + 1 + T_SETUP);
            end
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (pulses[i].data !== init_bytes[i] || pulses[i].rs !== 1'b0 ||
                    pulses[i].fall - pulses[i].rise != T_EN_HIGH ||
                    !pulses[i].setup_ok || !pulses[i].stable || !pulses[i].hold_ok) begin
                    errors++;
                    $display("FAIL %s_pulse%0d: got data=%02h rs=%b width=%0d su=%0d st=%0d ho=%0d required data=%02h rs=0 width=%0d su=st=ho=1",
                             tag, i, pulses[i].data, pulses[i].rs, pulses[i].fall - pulses[i].rise,
                             pulses[i].setup_ok, pulses[i].stable, pulses[i].hold_ok,
                             init_bytes[i], T_EN_HIGH);
                end
                if (i < 5) begin
                    exp_gap = T_HOLD + exec_wait(1'b0, init_bytes[i]) + 1 + T_SETUP;
                    checks++;
                    if (pulses[i+1].rise - pulses[i].fall != exp_gap) begin
                        errors++;
                        $display("FAIL %s_gap%0d: got %0d required %0d", tag, i,
                                 pulses[i+1].rise - pulses[i].fall, exp_gap);
                    end
                end
            end
            checks++;
            if (t_done != pulses[5].fall + T_HOLD + exec_wait(1'b0, init_bytes[5])) begin
                errors++;
                $display("FAIL %s_done_time: got %0d required %0d after last EN fall", tag,
                         t_done - pulses[5].fall, T_HOLD + exec_wait(1'b0, init_bytes[5]));
            end
        end
        tick();
        checks++;
        if (cmd_bus.cmd_ready !== 1'b1 || busy !== 1'b0 || init_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle_entry: ready=%b busy=%b done=%b required 1 0 1", tag,
                     cmd_bus.cmd_ready, busy, init_done);
        end
        checks++;
        if (rw_seen) begin
            errors++;
            $display("FAIL %s_rw_low: LCD_RW went high, required always 0", tag);
        end
    endtask

    task automatic test_data_write();
        int hs, rc;
        pulses.delete();
        send(1'b1, 8'h41, 0, hs);
        wait_ready("data", rc);
        checks++;
        if (rc - hs != ready_latency(1'b1, 8'h41)) begin
            errors++;
            $display("FAIL data_latency: got %0d required %0d", rc - hs, ready_latency(1'b1, 8'h41));
        end
        checks++;
        if (pulses.size() != 1) begin
            errors++;
            $display("FAIL data_pulse_count: got %0d required 1", pulses.size());
        end else begin
            checks++;
            if (pulses[0].data !== 8'h41 || pulses[0].rs !== 1'b1 ||
                pulses[0].rise != hs + T_SETUP || pulses[0].fall - pulses[0].rise != T_EN_HIGH ||
                !pulses[0].setup_ok || !pulses[0].hold_ok || !pulses[0].stable) begin
                errors++;
                $display("FAIL data_pulse: got data=%02h rs=%b rise=+%0d width=%0d su=%0d ho=%0d required 41 1 +%0d %0d 1 1",
                         pulses[0].data, pulses[0].rs, pulses[0].rise - hs,
                         pulses[0].fall - pulses[0].rise, pulses[0].setup_ok, pulses[0].hold_ok,
                         T_SETUP, T_EN_HIGH);
            end
        end
    endtask

    task automatic test_back_to_back();
        int hs1, hs2, rc;
        pulses.delete();
        send(1'b0, 8'h01, 1, hs1);
        send(1'b0, 8'h80, 0, hs2);
        wait_ready("b2b", rc);
        checks++;
        if (hs2 - hs1 != ready_latency(1'b0, 8'h01) + 1) begin
            errors++;
            $display("FAIL b2b_accept_gap: got %0d required %0d", hs2 - hs1, ready_latency(1'b0, 8'h01) + 1);
        end
        checks++;
        if (pulses.size() != 2) begin
            errors++;
            $display("FAIL b2b_pulse_count: got %0d required 2", pulses.size());
        end else begin
            checks++;
            if (pulses[0].data !== 8'h01 || pulses[1].data !== 8'h80 ||
                pulses[0].rs !== 1'b0 || pulses[1].rs !== 1'b0) begin
                errors++;
                $display("FAIL b2b_bytes: got %02h/%b %02h/%b required 01/0 80/0",
                         pulses[0].data, pulses[0].rs, pulses[1].data, pulses[1].rs);
            end
        end
    endtask

    task automatic test_ignore();
        int hs, rc, lat;
        bit bus_moved;
        pulses.delete();
        bus_moved = 0;
        send(1'b1, 8'hC5, 0, hs);
        lat = ready_latency(1'b1, 8'hC5);
        while (cyc < hs + lat - 2) begin
            cmd_bus.cmd_valid = 1'($urandom_range(0, 1));
            cmd_bus.cmd_rs    = 1'b0;
            cmd_bus.cmd_data  = 8'h5A;
            tick();
            if (LCD_DATA !== 8'hC5 || LCD_RS !== 1'b1) bus_moved = 1;
        end
        cmd_bus.cmd_valid = 1'b0;
        wait_ready("ignore", rc);
        checks++;
        if (bus_moved) begin
            errors++;
            $display("FAIL ignore_bus_held: LCD_RS/LCD_DATA changed while busy, required 1/C5");
        end
        checks++;
        if (rc - hs != lat) begin
            errors++;
            $display("FAIL ignore_latency: got %0d required %0d", rc - hs, lat);
        end
        repeat (6) tick();
        checks++;
        if (pulses.size() != 1 || cmd_bus.cmd_ready !== 1'b1 || LCD_DATA !== 8'hC5) begin
            errors++;
            $display("FAIL ignore_no_queue: pulses=%0d ready=%b data=%02h required 1 1 C5",
                     pulses.size(), cmd_bus.cmd_ready, LCD_DATA);
        end
    endtask

    task automatic test_random();
        logic       rs;
        logic [7:0] d;
        int         hs, rc;
        pulse_t     exp_q[$];
        pulse_t     e;
        pulses.delete();
        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                rs = 1'b0;
                d  = 8'($urandom_range(1, 3));
            end else begin
                rs = 1'($urandom_range(0, 1));
                d  = 8'($urandom_range(0, 255));
            end
            send(rs, d, 0, hs);
            wait_ready("rand", rc);
            checks++;
            if (rc - hs != ready_latency(rs, d)) begin
                errors++;
                $display("FAIL rand_latency%0d: byte %02h rs=%b got %0d required %0d",
                         n, d, rs, rc - hs, ready_latency(rs, d));
            end
            e.rs = rs;
            e.data = d;
            e.rise = hs + T_SETUP;
            exp_q.push_back(e);
            repeat ($urandom_range(0, 3)) tick();
        end
        checks++;
        if (pulses.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_pulse_count: got %0d required %0d", pulses.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (pulses[i].data !== exp_q[i].data || pulses[i].rs !== exp_q[i].rs ||
                    pulses[i].rise != exp_q[i].rise || pulses[i].fall - pulses[i].rise != T_EN_HIGH) begin
                    errors++;
                    $display("FAIL rand_pulse%0d: got %02h/%b rise %0d width %0d required %02h/%b rise %0d width %0d",
                             i, pulses[i].data, pulses[i].rs, pulses[i].rise, pulses[i].fall - pulses[i].rise,
                             exp_q[i].data, exp_q[i].rs, exp_q[i].rise, T_EN_HIGH);
                end
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        int hs;
        bit saw_en;
        saw_en = 0;
        send(1'b1, 8'h77, 0, hs);
        for (int i = 0; i < 20; i++) begin
            if (LCD_EN === 1'b1) begin
                saw_en = 1;
                break;
            end
            tick();
        end
        checks++;
        if (!saw_en) begin
            errors++;
            $display("FAIL rst_mid_en_seen: LCD_EN never rose for byte 77");
        end
        #2;
        PRESETn = 1'b0;
        #1;
        checks++;
        if (LCD_EN !== 1'b0 || LCD_DATA !== 8'h00 || init_done !== 1'b0 ||
            busy !== 1'b1 || cmd_bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: en=%b data=%02h done=%b busy=%b ready=%b required 0 00 0 1 0",
                     LCD_EN, LCD_DATA, init_done, busy, cmd_bus.cmd_ready);
        end
        repeat (3) tick();
        test_init_sequence("reinit", 1'b0);
    endtask

    initial begin
        test_reset();
        test_init_sequence("init", 1'b1);
        test_data_write();
        test_back_to_back();
        test_ignore();
        test_random();
        test_reset_mid_pulse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
